beam_thresh_servo: RTL and testbench
====================================

# beam_thresh_servo

Per-beam trigger-rate servo and threshold loader for the L1 beamformer. It counts `trigger` pulses from each beam over a fixed window and nudges that beam's threshold up or down to hold the rate near a target. It then drives the beamformer's threshold-load interface (`thresh`, `thresh_ce`, `update`) from the initiator side. It sits beside the beamformer and is the producer of that interface; the beamformer is its consumer.

## Interface
- `NBEAMS`, 8, number of beams; must match the beamformer.
- `CNT_BITS`, 16, width of the per-beam trigger counters.
- `WINDOW_CYCLES`, 1000000, counting window length in clocks. Must be ≥ 2·NBEAMS+2; violating this is an elaboration error.
- `THRESH_INIT`, 9000, threshold loaded to every beam after reset.
- `STEP`, 16, threshold increment/decrement per window.
- `clk_i` input 1: single clock.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `trigger_i` input NBEAMS: per-beam trigger from the beamformer; one count per high cycle.
- `enable_i` input 1: servo enable, sampled at the window terminal cycle.
- `target_i` input CNT_BITS: desired triggers per window.
- `tol_i` input CNT_BITS: deadband half-width.
- `thresh_o` output 18: threshold value.
- `thresh_ce_o` output NBEAMS: one-hot write strobe, qualifies `thresh_o`.
- `update_o` output 1: one-cycle pulse that applies the written thresholds.
- `busy_o` output 1: high during INIT_WR, CALC, WRITE and UPDATE.

## Operation
- State machine: INIT_WR → UPDATE → COUNT → (CALC → WRITE → UPDATE → COUNT).
- **INIT_WR** (NBEAMS cycles):
  - beam b, in cycle b, gets `thresh_ce_o[b]`=1 and `thresh_o`=THRESH_INIT;
  - the internal threshold registers are set to THRESH_INIT.
- **UPDATE** (1 cycle): `update_o`=1, `thresh_ce_o`=0; next state COUNT with the window counter at 0.
- **COUNT**:
  - every cycle, `cnt[b]` += `trigger_i[b]`, saturating at 2^CNT_BITS−1 with no wrap;
  - the window counter runs 0..WINDOW_CYCLES−1.
- **Terminal cycle** (window counter = WINDOW_CYCLES−1):
  - `snap[b]` = sat(`cnt[b]` + `trigger_i[b]`), so the terminal-cycle trigger is included;
  - `cnt` clears to 0 and the window counter wraps to 0;
  - counting continues uninterrupted in all states;
  - if `enable_i`=1 → CALC; else stay in COUNT with no writes.
- **CALC** (NBEAMS cycles, one beam per cycle). Compares use CNT_BITS+1-bit arithmetic:
  - if `snap` > `target_i`+`tol_i`: `thr` = min(`thr`+STEP, 2^18−1);
  - else if `snap`+`tol_i` < `target_i`: `thr` = max(`thr`−STEP, 0);
  - otherwise unchanged.
- **WRITE** (NBEAMS cycles): beam b in cycle b gets `thresh_ce_o[b]`=1 and `thresh_o`=`thr[b]`. Every beam is written, including unchanged ones. Then UPDATE.
- **Reset mid-operation**:
  - all state is discarded and outputs go to reset values immediately;
  - after release the full INIT_WR sequence reruns.
- `target_i`/`tol_i` are sampled during CALC and must be held stable during it.

## Timing
- Reset values: `thresh_o`=0, `thresh_ce_o`=0, `update_o`=0, `busy_o`=0, counters 0, `thr[*]`=THRESH_INIT.
- All outputs are registered.
- First rising edge after `rst_ni` rises:
  - `thresh_ce_o`=0x01 and `busy_o`=1;
  - edges 1..NBEAMS walk the one-hot strobe;
  - edge NBEAMS+1 has `update_o`=1;
  - edge NBEAMS+2 is COUNT, window cycle 0, `busy_o`=0.
- `thresh_o` is valid only while a `thresh_ce_o` bit is set; otherwise it holds its last value.
- At most one `thresh_ce_o` bit is high per cycle. `update_o` never coincides with any `thresh_ce_o` bit.
- Terminal cycle at T:
  - CALC occupies T+1..T+NBEAMS;
  - WRITE occupies T+NBEAMS+1..T+2·NBEAMS;
  - `update_o` is at T+2·NBEAMS+1;
  - `busy_o` falls at T+2·NBEAMS+2.
- The parameter constraint guarantees the servo finishes before the next terminal cycle.

## Test plan
All scenarios use NBEAMS=8, WINDOW_CYCLES=64, STEP=16, THRESH_INIT=9000 unless overridden.

- **Reset release** → edges 1–8: `thresh_ce_o` = 0x01, 0x02 … 0x80 with `thresh_o`=9000; edge 9: `update_o`=1; edge 10: `busy_o`=0.
- **Rate servo**: `enable_i`=1, `target_i`=10, `tol_i`=2, `trigger_i[3]` high all window, others low → beam 3 (snap 64) written 9016; other beams (snap 0) written 8984; `update_o` fires 17 cycles after the terminal cycle.
- **Deadband and terminal sample**: `target_i`=5, `tol_i`=0, beam 0 gets exactly 4 pulses plus one in the terminal cycle → snap 5, beam 0 rewritten 9000.
- **Saturation**:
  - CNT_BITS=4, trigger held 64 cycles → snap 15, threshold rises, no wrap;
  - THRESH_INIT=20 with zero triggers and `target_i`=10 → writes 4, then 0, then stays 0.
- **Disable**: `enable_i`=0 at terminal cycle → no `thresh_ce_o`/`update_o` that window, `busy_o` stays 0, counters still cleared.
- **Reset mid-WRITE**: drop `rst_ni` while `thresh_ce_o`=0x08 → all outputs 0 asynchronously; after release INIT_WR reruns writing 9000 to all beams.

Source files
------------

// File: rtl/beam_thresh_servo.sv
// Per-beam trigger-rate servo: counts triggers per window, nudges each beam's
// threshold toward a target rate and drives the beamformer threshold-load port.
module beam_thresh_servo #(
  parameter int NBEAMS        = 8,
  parameter int CNT_BITS      = 16,
  parameter int WINDOW_CYCLES = 1000000,
  parameter int THRESH_INIT   = 9000,
  parameter int STEP          = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NBEAMS-1:0]   trigger_i,
  input  logic                enable_i,
  input  logic [CNT_BITS-1:0] target_i,
  input  logic [CNT_BITS-1:0] tol_i,
  output logic [17:0]         thresh_o,
  output logic [NBEAMS-1:0]   thresh_ce_o,
  output logic                update_o,
  output logic                busy_o
);
  localparam int TW    = 18;
  localparam int IDX_W = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;
  localparam int WIN_W = $clog2(WINDOW_CYCLES);

  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NBEAMS - 1);
  localparam logic [WIN_W-1:0]    LAST_WIN = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [TW-1:0]       INIT_T   = TW'(THRESH_INIT);
  localparam logic [TW-1:0]       STEP_T   = TW'(STEP);
  localparam logic [TW:0]         STEP_W   = {1'b0, STEP_T};
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

  if (WINDOW_CYCLES < 2 * NBEAMS + 2) begin : g_bad_window
    $error("beam_thresh_servo: WINDOW_CYCLES must be >= 2*NBEAMS+2");
  end

  typedef enum logic [2:0] {
    S_RESET,
    S_INIT,
    S_UPDATE,
    S_COUNT,
    S_CALC,
    S_WRITE
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [WIN_W-1:0]    r_win;
  logic                r_run;
  logic [CNT_BITS-1:0] r_cnt  [NBEAMS];
  logic [CNT_BITS-1:0] r_snap [NBEAMS];
  logic [TW-1:0]       r_thr  [NBEAMS];
  logic [TW-1:0]       r_thresh;
  logic [NBEAMS-1:0]   r_ce;
  logic                r_update;
  logic                r_busy;

  logic                w_term;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [TW-1:0]       w_thr_new;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c,
                                                  input logic             t);
    return (t && (c != CNT_MAX)) ? c + 1'b1 : c;
  endfunction

  // Deadband compares run one bit wider so target+tol and snap+tol cannot wrap.
  function automatic logic [TW-1:0] servo_step(input logic [TW-1:0]       thr,
                                               input logic [CNT_BITS-1:0] snap,
                                               input logic [CNT_BITS-1:0] target,
                                               input logic [CNT_BITS-1:0] tol);
    logic [CNT_BITS:0] hi;
    logic [CNT_BITS:0] lo;
    logic [TW:0]       up;
    hi = {1'b0, target} + {1'b0, tol};
    lo = {1'b0, snap} + {1'b0, tol};
    up = {1'b0, thr} + STEP_W;
    if ({1'b0, snap} > hi)
      return up[TW] ? '1 : up[TW-1:0];
    else if (lo < {1'b0, target})
      return (thr < STEP_T) ? '0 : thr - STEP_T;
    else
      return thr;
  endfunction

  function automatic logic [NBEAMS-1:0] onehot(input logic [IDX_W-1:0] i);
    return NBEAMS'(1) << i;
  endfunction

  assign w_term    = r_run && (r_win == LAST_WIN);
  assign w_idx_nxt = r_idx + 1'b1;
  assign w_thr_new = servo_step(r_thr[r_idx], r_snap[r_idx], target_i, tol_i);

  // Window counter and per-beam trigger counters; free-running once started.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_win <= '0;
      for (int b = 0; b < NBEAMS; b++) begin
        r_cnt[b]  <= '0;
        r_snap[b] <= '0;
      end
    end else if (r_run) begin
      r_win <= w_term ? '0 : r_win + 1'b1;
      for (int b = 0; b < NBEAMS; b++) begin
        if (w_term) begin
          r_snap[b] <= sat_inc(r_cnt[b], trigger_i[b]);
          r_cnt[b]  <= '0;
        end else begin
          r_cnt[b]  <= sat_inc(r_cnt[b], trigger_i[b]);
        end
      end
    end
  end

  // Sequencer: outputs are registered alongside the state they belong to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_RESET;
      r_idx    <= '0;
      r_run    <= 1'b0;
      r_thresh <= '0;
      r_ce     <= '0;
      r_update <= 1'b0;
      r_busy   <= 1'b0;
      for (int b = 0; b < NBEAMS; b++) r_thr[b] <= INIT_T;
    end else begin
      r_update <= 1'b0;
      r_ce     <= '0;
      case (r_state)
        S_RESET: begin
          r_state  <= S_INIT;
          r_idx    <= '0;
          r_ce     <= onehot('0);
          r_thresh <= INIT_T;
          r_busy   <= 1'b1;
          for (int b = 0; b < NBEAMS; b++) r_thr[b] <= INIT_T;
        end
        S_INIT: begin
          if (r_idx == LAST_IDX) begin
            r_state  <= S_UPDATE;
            r_update <= 1'b1;
          end else begin
            r_idx    <= w_idx_nxt;
            r_ce     <= onehot(w_idx_nxt);
            r_thresh <= INIT_T;
          end
        end
        S_UPDATE: begin
          r_state <= S_COUNT;
          r_busy  <= 1'b0;
          r_run   <= 1'b1;
        end
        S_COUNT: begin
          if (w_term && enable_i) begin
            r_state <= S_CALC;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_CALC: begin
          r_thr[r_idx] <= w_thr_new;
          if (r_idx == LAST_IDX) begin
            r_state  <= S_WRITE;
            r_idx    <= '0;
            r_ce     <= onehot('0);
            r_thresh <= (NBEAMS == 1) ? w_thr_new : r_thr[0];
          end else begin
            r_idx <= w_idx_nxt;
          end
        end
        S_WRITE: begin
          if (r_idx == LAST_IDX) begin
            r_state  <= S_UPDATE;
            r_update <= 1'b1;
          end else begin
            r_idx    <= w_idx_nxt;
            r_ce     <= onehot(w_idx_nxt);
            r_thresh <= r_thr[w_idx_nxt];
          end
        end
        default: r_state <= S_RESET;
      endcase
    end
  end

  assign thresh_o    = r_thresh;
  assign thresh_ce_o = r_ce;
  assign update_o    = r_update;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_beam_thresh_servo.sv
// Directed bench for beam_thresh_servo: three instances (default, 4-bit
// counters, low initial threshold) share clock and reset, windows of 64 cycles.
module tb_beam_thresh_servo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_no;

  // Rising edges since reset release; edge 1 is the first after release.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) edge_no <= 0;
    else        edge_no <= edge_no + 1;

  logic [7:0]  trig1 = '0, trig2 = '0, trig3 = '0;
  logic        en1 = 1'b0, en2 = 1'b0, en3 = 1'b0;
  logic [15:0] tgt1 = '0, tol1 = '0, tgt3 = '0, tol3 = '0;
  logic [3:0]  tgt2 = '0, tol2 = '0;
  logic [17:0] thr1, thr2, thr3;
  logic [7:0]  ce1, ce2, ce3;
  logic        upd1, upd2, upd3, busy1, busy2, busy3;

  beam_thresh_servo #(.NBEAMS(8), .CNT_BITS(16), .WINDOW_CYCLES(64),
                      .THRESH_INIT(9000), .STEP(16)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .trigger_i(trig1), .enable_i(en1),
    .target_i(tgt1), .tol_i(tol1), .thresh_o(thr1), .thresh_ce_o(ce1),
    .update_o(upd1), .busy_o(busy1));

  beam_thresh_servo #(.NBEAMS(8), .CNT_BITS(4), .WINDOW_CYCLES(64),
                      .THRESH_INIT(9000), .STEP(16)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .trigger_i(trig2), .enable_i(en2),
    .target_i(tgt2), .tol_i(tol2), .thresh_o(thr2), .thresh_ce_o(ce2),
    .update_o(upd2), .busy_o(busy2));

  beam_thresh_servo #(.NBEAMS(8), .CNT_BITS(16), .WINDOW_CYCLES(64),
                      .THRESH_INIT(20), .STEP(16)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .trigger_i(trig3), .enable_i(en3),
    .target_i(tgt3), .tol_i(tol3), .thresh_o(thr3), .thresh_ce_o(ce3),
    .update_o(upd3), .busy_o(busy3));

  // Park on the falling edge that follows rising edge n.
  task automatic goto(input int n);
    while (edge_no < n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] exp_ce;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({thr1, ce1, upd1, busy1} !== '0) begin
      n_fail++;
      $display("FAIL rst_hold: thresh=%0d ce=%h upd=%b busy=%b want all 0", thr1, ce1, upd1, busy1);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      goto(k);
      exp_ce = 8'h01 << (k - 1);
      n_tests++;
      if (ce1 !== exp_ce || thr1 !== 18'd9000 || busy1 !== 1'b1 || upd1 !== 1'b0) begin
        n_fail++;
        $display("FAIL init_wr edge %0d: ce=%h thresh=%0d busy=%b upd=%b want ce=%h thresh=9000 busy=1 upd=0",
                 k, ce1, thr1, busy1, upd1, exp_ce);
      end
    end
    goto(9);
    n_tests++;
    if (upd1 !== 1'b1 || ce1 !== 8'h00 || busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL init_update: upd=%b ce=%h busy=%b want upd=1 ce=00 busy=1", upd1, ce1, busy1);
    end
    goto(10);
    n_tests++;
    if (busy1 !== 1'b0 || upd1 !== 1'b0 || ce1 !== 8'h00) begin
      n_fail++;
      $display("FAIL init_count: busy=%b upd=%b ce=%h want 0 0 00", busy1, upd1, ce1);
    end
  endtask

  // Window 1: beam 3 high every cycle (snap 64), others idle (snap 0).
  task automatic test_rate_servo();
    logic [7:0]  exp_ce;
    logic [17:0] exp_thr;
    en1 = 1'b1; tgt1 = 16'd10; tol1 = 16'd2; trig1 = 8'h08;
    goto(73);
    goto(74);
    trig1 = 8'h00;
    n_tests++;
    if (busy1 !== 1'b1 || ce1 !== 8'h00) begin
      n_fail++;
      $display("FAIL servo_calc_start: busy=%b ce=%h want busy=1 ce=00", busy1, ce1);
    end
    for (int b = 0; b < 8; b++) begin
      goto(82 + b);
      exp_ce  = 8'h01 << b;
      exp_thr = (b == 3) ? 18'd9016 : 18'd8984;
      n_tests++;
      if (ce1 !== exp_ce || thr1 !== exp_thr) begin
        n_fail++;
        $display("FAIL servo_write beam %0d: ce=%h thresh=%0d want ce=%h thresh=%0d", b, ce1, thr1, exp_ce, exp_thr);
      end
    end
    goto(90);
    n_tests++;
    if (upd1 !== 1'b1 || ce1 !== 8'h00) begin
      n_fail++;
      $display("FAIL servo_update: upd=%b ce=%h want upd=1 ce=00", upd1, ce1);
    end
    goto(91);
    n_tests++;
    if (busy1 !== 1'b0 || upd1 !== 1'b0) begin
      n_fail++;
      $display("FAIL servo_idle: busy=%b upd=%b want 0 0", busy1, upd1);
    end
  endtask

  // Window 2 (no triggers): beam 3 drops 9016 -> 9000; reset lands on its strobe.
  task automatic test_reset_mid_write();
    logic [7:0] exp_ce;
    bit found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (ce1 === 8'h08) found = 1'b1;
    end
    n_tests++;
    if (!found || edge_no != 149 || thr1 !== 18'd9000) begin
      n_fail++;
      $display("FAIL midwr_reach: found=%b edge=%0d thresh=%0d want found=1 edge=149 thresh=9000", found, edge_no, thr1);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({thr1, ce1, upd1, busy1} !== '0) begin
      n_fail++;
      $display("FAIL midwr_async: thresh=%0d ce=%h upd=%b busy=%b want all 0", thr1, ce1, upd1, busy1);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      goto(k);
      exp_ce = 8'h01 << (k - 1);
      n_tests++;
      if (ce1 !== exp_ce || thr1 !== 18'd9000 || busy1 !== 1'b1) begin
        n_fail++;
        $display("FAIL midwr_rerun edge %0d: ce=%h thresh=%0d busy=%b want ce=%h thresh=9000 busy=1",
                 k, ce1, thr1, busy1, exp_ce);
      end
    end
    goto(9);
    n_tests++;
    if (upd1 !== 1'b1) begin
      n_fail++;
      $display("FAIL midwr_update: upd=%b want 1", upd1);
    end
    goto(10);
  endtask

  // Beam 0: four pulses mid-window plus one in the terminal cycle -> snap 5.
  task automatic test_deadband();
    logic [7:0]  exp_ce;
    logic [17:0] exp_thr;
    en1 = 1'b1; tgt1 = 16'd5; tol1 = 16'd0; trig1 = 8'h00;
    goto(20); trig1 = 8'h01;
    goto(24); trig1 = 8'h00;
    goto(73); trig1 = 8'h01;
    goto(74); trig1 = 8'h00;
    for (int b = 0; b < 8; b++) begin
      goto(82 + b);
      exp_ce  = 8'h01 << b;
      exp_thr = (b == 0) ? 18'd9000 : 18'd8984;
      n_tests++;
      if (ce1 !== exp_ce || thr1 !== exp_thr) begin
        n_fail++;
        $display("FAIL deadband_write beam %0d: ce=%h thresh=%0d want ce=%h thresh=%0d", b, ce1, thr1, exp_ce, exp_thr);
      end
    end
    goto(90);
    n_tests++;
    if (upd1 !== 1'b1) begin
      n_fail++;
      $display("FAIL deadband_update: upd=%b want 1", upd1);
    end
  endtask

  // Window 2 disabled with 9 beam-0 pulses; window 3 must start from a clear count.
  task automatic test_disable();
    logic [7:0]  exp_ce;
    logic [17:0] exp_thr;
    goto(91);
    en1 = 1'b0; tgt1 = 16'd10; tol1 = 16'd2;
    goto(100); trig1 = 8'h01;
    goto(109); trig1 = 8'h00;
    for (int j = 136; j <= 160; j++) begin
      goto(j);
      n_tests++;
      if (ce1 !== 8'h00 || upd1 !== 1'b0 || busy1 !== 1'b0) begin
        n_fail++;
        $display("FAIL disable_quiet edge %0d: ce=%h upd=%b busy=%b want 00 0 0", j, ce1, upd1, busy1);
      end
    end
    en1 = 1'b1;
    for (int b = 0; b < 8; b++) begin
      goto(210 + b);
      exp_ce  = 8'h01 << b;
      exp_thr = (b == 0) ? 18'd8984 : 18'd8968;
      n_tests++;
      if (ce1 !== exp_ce || thr1 !== exp_thr) begin
        n_fail++;
        $display("FAIL disable_cleared beam %0d: ce=%h thresh=%0d want ce=%h thresh=%0d", b, ce1, thr1, exp_ce, exp_thr);
      end
    end
    goto(218);
    n_tests++;
    if (upd1 !== 1'b1) begin
      n_fail++;
      $display("FAIL disable_update: upd=%b want 1", upd1);
    end
  endtask

  // 4-bit counters, beam 0 high for all 64 cycles of window 5 -> snap 15.
  task automatic test_sat_count();
    logic [7:0]  exp_ce;
    logic [17:0] exp_thr;
    goto(266);
    trig2 = 8'h01; en2 = 1'b1; tgt2 = 4'd10; tol2 = 4'd2;
    goto(330);
    trig2 = 8'h00;
    for (int b = 0; b < 8; b++) begin
      goto(338 + b);
      exp_ce  = 8'h01 << b;
      exp_thr = (b == 0) ? 18'd9016 : 18'd8984;
      n_tests++;
      if (ce2 !== exp_ce || thr2 !== exp_thr) begin
        n_fail++;
        $display("FAIL satcnt_write beam %0d: ce=%h thresh=%0d want ce=%h thresh=%0d", b, ce2, thr2, exp_ce, exp_thr);
      end
    end
    goto(346);
    n_tests++;
    if (upd2 !== 1'b1) begin
      n_fail++;
      $display("FAIL satcnt_update: upd=%b want 1", upd2);
    end
  endtask

  // THRESH_INIT=20, no triggers: 20 -> 4 -> 0 -> 0 over windows 6..8.
  task automatic test_thresh_floor();
    int          term [3];
    logic [17:0] exp_thr [3];
    term[0] = 393; term[1] = 457; term[2] = 521;
    exp_thr[0] = 18'd4; exp_thr[1] = 18'd0; exp_thr[2] = 18'd0;
    goto(347);
    en3 = 1'b1; tgt3 = 16'd10; tol3 = 16'd0; trig3 = 8'h00;
    for (int w = 0; w < 3; w++) begin
      goto(term[w] + 9);
      n_tests++;
      if (ce3 !== 8'h01 || thr3 !== exp_thr[w]) begin
        n_fail++;
        $display("FAIL floor_beam0 window %0d: ce=%h thresh=%0d want ce=01 thresh=%0d", w, ce3, thr3, exp_thr[w]);
      end
      goto(term[w] + 16);
      n_tests++;
      if (ce3 !== 8'h80 || thr3 !== exp_thr[w]) begin
        n_fail++;
        $display("FAIL floor_beam7 window %0d: ce=%h thresh=%0d want ce=80 thresh=%0d", w, ce3, thr3, exp_thr[w]);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_rate_servo();
    test_reset_mid_write();
    test_deadband();
    test_disable();
    test_sat_count();
    test_thresh_floor();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
